// File: rtl/eqa_mc.sv
// Multi-channel cascaded first-order equalizer. One shared multiply-add datapath
// walks every band of every channel per frame; coefficients are double-buffered.
module eqa_mc #(
  parameter int NUM_CH                 = 2,
  parameter int NUM_BANDS              = 5,
  parameter int SINGLE_ADC_WIDTH       = 16,
  parameter int SINGLE_DAC_WIDTH       = 19,
  parameter int COEFFICIENT_DATA_WIDTH = 18,
  localparam int BAND_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 ce,
  input  logic [NUM_CH*SINGLE_ADC_WIDTH-1:0]   Eqa_in,
  input  logic                                 eqa_start,
  input  logic                                 coeff_wr,
  input  logic [BAND_W-1:0]                    coeff_band,
  input  logic [COEFFICIENT_DATA_WIDTH-1:0]    coeff_a,
  input  logic [COEFFICIENT_DATA_WIDTH-1:0]    coeff_b,
  input  logic                                 coeff_commit,
  input  logic [NUM_BANDS-1:0]                 band_bypass,
  input  logic                                 hist_clr,
  output logic [NUM_CH*SINGLE_DAC_WIDTH-1:0]   Eqa_Out,
  output logic                                 eqa_busy,
  output logic                                 eqa_Done
);

  localparam int AW   = SINGLE_ADC_WIDTH;
  localparam int DW   = SINGLE_DAC_WIDTH;
  localparam int CW   = COEFFICIENT_DATA_WIDTH;
  localparam int PW   = CW + DW;
  localparam int SW   = PW + 1;
  localparam int FRAC = 16;
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CW-1:0]     COEF_ONE  = {{(CW-1){1'b0}}, 1'b1} << FRAC;
  localparam logic [CW-1:0]     COEF_ZERO = {CW{1'b0}};
  localparam logic [BAND_W-1:0] LAST_BAND = BAND_W'(NUM_BANDS - 1);
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [BAND_W-1:0]       band_q, band_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic                    busy_q, done_q;
  logic                    commit_pend_q, hist_pend_q;
  logic [AW-1:0]           smp_q [NUM_CH];
  logic [NUM_BANDS-1:0]    byp_q;
  logic signed [DW-1:0]    x_q;
  logic signed [DW-1:0]    res_q [NUM_CH];
  logic [NUM_CH*DW-1:0]    out_q, out_d;
  logic signed [DW-1:0]    yprev_q [NUM_CH][NUM_BANDS];
  logic signed [CW-1:0]    a_stg_q [NUM_BANDS];
  logic signed [CW-1:0]    b_stg_q [NUM_BANDS];
  logic signed [CW-1:0]    a_act_q [NUM_BANDS];
  logic signed [CW-1:0]    b_act_q [NUM_BANDS];

  logic                    idle_s, run_s, last_band_s;
  logic                    apply_commit_s, apply_hist_s, stg_wr_s;
  logic signed [DW-1:0]    x_cur_s, yp_cur_s, y_filt_s, y_out_s;
  logic signed [CW-1:0]    a_cur_s, b_cur_s;
  logic signed [PW-1:0]    prod_a_s, prod_b_s;
  logic signed [SW-1:0]    sum_s, shr_s;

  function automatic logic signed [DW-1:0] sat_dac(input logic signed [SW-1:0] v);
    logic [SW-DW:0] top;
    top = v[SW-1:DW-1];
    if ((&top) || (~|top)) begin
      return v[DW-1:0];
    end else if (v[SW-1]) begin
      return {1'b1, {(DW-1){1'b0}}};
    end else begin
      return {1'b0, {(DW-1){1'b1}}};
    end
  endfunction

  always_comb begin
    idle_s         = (state_q == S_IDLE);
    run_s          = (state_q == S_RUN);
    last_band_s    = (band_q == LAST_BAND);
    apply_commit_s = idle_s && (commit_pend_q || coeff_commit);
    apply_hist_s   = idle_s && (hist_pend_q || hist_clr);
    stg_wr_s       = coeff_wr && (int'(coeff_band) < NUM_BANDS);
  end

  // Shared multiply-add: one band of one channel per RUN cycle.
  always_comb begin
    a_cur_s  = a_act_q[band_q];
    b_cur_s  = b_act_q[band_q];
    yp_cur_s = yprev_q[ch_q][band_q];
    if (band_q == {BAND_W{1'b0}}) begin
      x_cur_s = {{(DW-AW){smp_q[ch_q][AW-1]}}, smp_q[ch_q]};
    end else begin
      x_cur_s = x_q;
    end
    prod_b_s = $signed({{DW{b_cur_s[CW-1]}}, b_cur_s}) * $signed({{CW{x_cur_s[DW-1]}}, x_cur_s});
    prod_a_s = $signed({{DW{a_cur_s[CW-1]}}, a_cur_s}) * $signed({{CW{yp_cur_s[DW-1]}}, yp_cur_s});
    sum_s    = $signed({prod_a_s[PW-1], prod_a_s}) + $signed({prod_b_s[PW-1], prod_b_s});
    shr_s    = sum_s >>> FRAC;
    y_filt_s = sat_dac(shr_s);
    if (byp_q[band_q]) begin
      y_out_s = x_cur_s;
    end else begin
      y_out_s = y_filt_s;
    end
  end

  always_comb begin
    state_d = state_q;
    band_d  = band_q;
    ch_d    = ch_q;
    case (state_q)
      S_IDLE: begin
        if (eqa_start) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        state_d = S_RUN;
        band_d  = {BAND_W{1'b0}};
        ch_d    = {CH_W{1'b0}};
      end
      S_RUN: begin
        if (last_band_s) begin
          band_d = {BAND_W{1'b0}};
          if (ch_q == LAST_CH) begin
            state_d = S_DONE;
          end else begin
            ch_d = ch_q + CH_W'(1);
          end
        end else begin
          band_d = band_q + BAND_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    out_d = {(NUM_CH*DW){1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      out_d[(NUM_CH-1-c)*DW +: DW] = res_q[c];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      band_q        <= {BAND_W{1'b0}};
      ch_q          <= {CH_W{1'b0}};
      busy_q        <= 1'b0;
      commit_pend_q <= 1'b0;
      hist_pend_q   <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      band_q  <= band_d;
      ch_q    <= ch_d;
      busy_q  <= (state_d != S_IDLE);
      // Requests arriving while busy wait here until the FSM is back in IDLE.
      if (idle_s) begin
        commit_pend_q <= 1'b0;
        hist_pend_q   <= 1'b0;
      end else begin
        commit_pend_q <= commit_pend_q | coeff_commit;
        hist_pend_q   <= hist_pend_q | hist_clr;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q <= 1'b0;
      out_q  <= {(NUM_CH*DW){1'b0}};
    end else begin
      done_q <= ce && (state_q == S_DONE);
      if (ce && (state_q == S_DONE)) begin
        out_q <= out_d;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byp_q <= {NUM_BANDS{1'b0}};
      x_q   <= {DW{1'b0}};
      for (int c = 0; c < NUM_CH; c++) begin
        smp_q[c] <= {AW{1'b0}};
        res_q[c] <= {DW{1'b0}};
      end
    end else if (ce) begin
      if (state_q == S_LOAD) begin
        byp_q <= band_bypass;
        for (int c = 0; c < NUM_CH; c++) begin
          smp_q[c] <= Eqa_in[(NUM_CH-1-c)*AW +: AW];
        end
      end
      if (run_s) begin
        x_q <= y_out_s;
        if (last_band_s) begin
          res_q[ch_q] <= y_out_s;
        end
      end
    end
  end

  // Bypassed bands leave their history untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int b = 0; b < NUM_BANDS; b++) begin
          yprev_q[c][b] <= {DW{1'b0}};
        end
      end
    end else if (ce) begin
      if (apply_hist_s) begin
        for (int c = 0; c < NUM_CH; c++) begin
          for (int b = 0; b < NUM_BANDS; b++) begin
            yprev_q[c][b] <= {DW{1'b0}};
          end
        end
      end else if (run_s && !byp_q[band_q]) begin
        yprev_q[ch_q][band_q] <= y_out_s;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < NUM_BANDS; b++) begin
        a_stg_q[b] <= COEF_ZERO;
        b_stg_q[b] <= COEF_ONE;
        a_act_q[b] <= COEF_ZERO;
        b_act_q[b] <= COEF_ONE;
      end
    end else if (ce) begin
      if (apply_commit_s) begin
        for (int b = 0; b < NUM_BANDS; b++) begin
          a_act_q[b] <= a_stg_q[b];
          b_act_q[b] <= b_stg_q[b];
        end
      end
      if (stg_wr_s) begin
        a_stg_q[coeff_band] <= coeff_a;
        b_stg_q[coeff_band] <= coeff_b;
      end
    end
  end

  assign Eqa_Out  = out_q;
  assign eqa_busy = busy_q;
  assign eqa_Done = done_q;

endmodule

// File: tb/tb_eqa_mc.sv
// Self-checking bench for eqa_mc: frame-level reference model compared every
// cycle, plus directed literal checks of the equalizer's headline behaviours.
module tb_eqa_mc;

  localparam int NCH = 2;
  localparam int NB  = 5;
  localparam int AW  = 16;
  localparam int DW  = 19;
  localparam int CW  = 18;
  localparam int LAT = NCH*NB + 2;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                ce = 1'b1;
  logic [NCH*AW-1:0]   Eqa_in = '0;
  logic                eqa_start = 1'b0;
  logic                coeff_wr = 1'b0;
  logic [2:0]          coeff_band = 3'd0;
  logic [CW-1:0]       coeff_a = '0;
  logic [CW-1:0]       coeff_b = '0;
  logic                coeff_commit = 1'b0;
  logic [NB-1:0]       band_bypass = '0;
  logic                hist_clr = 1'b0;
  logic [NCH*DW-1:0]   Eqa_Out;
  logic                eqa_busy;
  logic                eqa_Done;

  eqa_mc #(
    .NUM_CH(NCH), .NUM_BANDS(NB), .SINGLE_ADC_WIDTH(AW),
    .SINGLE_DAC_WIDTH(DW), .COEFFICIENT_DATA_WIDTH(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .Eqa_in(Eqa_in), .eqa_start(eqa_start),
    .coeff_wr(coeff_wr), .coeff_band(coeff_band), .coeff_a(coeff_a), .coeff_b(coeff_b),
    .coeff_commit(coeff_commit), .band_bypass(band_bypass), .hist_clr(hist_clr),
    .Eqa_Out(Eqa_Out), .eqa_busy(eqa_busy), .eqa_Done(eqa_Done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model (frame level) ----------------
  int     stg_a [NB], stg_b [NB], act_a [NB], act_b [NB];
  longint yp [NCH][NB];
  longint res [NCH];
  longint m_out [NCH];
  bit     m_busy, m_done, pend_c, pend_h;
  int     m_cnt;

  function automatic longint sat_dac(input longint v);
    longint hi, lo;
    hi = (longint'(1) <<< (DW-1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      stg_a[b] = 0; stg_b[b] = 65536; act_a[b] = 0; act_b[b] = 65536;
      for (int c = 0; c < NCH; c++) yp[c][b] = 0;
    end
    for (int c = 0; c < NCH; c++) begin res[c] = 0; m_out[c] = 0; end
    m_busy = 1'b0; m_done = 1'b0; pend_c = 1'b0; pend_h = 1'b0; m_cnt = 0;
  endtask

  task automatic model_frame();
    longint x, y;
    for (int c = 0; c < NCH; c++) begin
      x = longint'($signed(Eqa_in[(NCH-1-c)*AW +: AW]));
      for (int b = 0; b < NB; b++) begin
        if (band_bypass[b]) y = x;
        else begin
          y = sat_dac((longint'(act_b[b]) * x + longint'(act_a[b]) * yp[c][b]) >>> 16);
          yp[c][b] = y;
        end
        x = y;
      end
      res[c] = x;
    end
  endtask

  task automatic model_step();
    if (!reset_n) model_reset();
    else if (!ce) m_done = 1'b0;
    else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (pend_c || coeff_commit) begin
          for (int b = 0; b < NB; b++) begin act_a[b] = stg_a[b]; act_b[b] = stg_b[b]; end
          pend_c = 1'b0;
        end
        if (pend_h || hist_clr) begin
          for (int c = 0; c < NCH; c++) for (int b = 0; b < NB; b++) yp[c][b] = 0;
          pend_h = 1'b0;
        end
        if (eqa_start) begin m_busy = 1'b1; m_cnt = 0; end
      end else begin
        if (coeff_commit) pend_c = 1'b1;
        if (hist_clr) pend_h = 1'b1;
        m_cnt++;
        if (m_cnt == 1) model_frame();
        if (m_cnt == LAT) begin
          for (int c = 0; c < NCH; c++) m_out[c] = res[c];
          m_done = 1'b1;
          m_busy = 1'b0;
        end
      end
      if (coeff_wr && int'(coeff_band) < NB) begin
        stg_a[coeff_band] = int'($signed(coeff_a));
        stg_b[coeff_band] = int'($signed(coeff_b));
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      model_step();
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("cyc_done", 64'(eqa_Done), 64'(m_done));
        chk("cyc_busy", 64'(eqa_busy), 64'(m_busy));
        chk("cyc_out", 64'(Eqa_Out), 64'({DW'(m_out[0]), DW'(m_out[1])}));
      end
    end
  end

  // ---------------- directed stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic run_frame(input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                           output logic [DW-1:0] o0, output logic [DW-1:0] o1, output int lat);
    Eqa_in = {s0, s1};
    eqa_start = 1'b1;
    step(1);
    eqa_start = 1'b0;
    lat = 0;
    while (!eqa_Done && lat < 40) begin step(1); lat++; end
    o0 = Eqa_Out[2*DW-1:DW];
    o1 = Eqa_Out[DW-1:0];
  endtask

  task automatic wr_coef(input int band, input logic [CW-1:0] a, input logic [CW-1:0] b);
    coeff_wr = 1'b1; coeff_band = 3'(band); coeff_a = a; coeff_b = b;
    step(1);
    coeff_wr = 1'b0;
  endtask

  task automatic commit();
    coeff_commit = 1'b1; step(1); coeff_commit = 1'b0;
  endtask

  task automatic clear_hist();
    hist_clr = 1'b1; step(1); hist_clr = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] o0, o1;
    int lat, nd;

    reset_n = 1'b0;
    step(3);
    reset_n = 1'b1;
    chk_en = 1'b1;
    step(1);
    chk("rst_out", 64'(Eqa_Out), 64'd0);
    chk("rst_busy", 64'(eqa_busy), 64'd0);
    chk("rst_done", 64'(eqa_Done), 64'd0);

    // Passthrough after reset.
    run_frame(16'h1234, 16'hFFFF, o0, o1, lat);
    chk("pass_lat", 64'(lat), 64'd12);
    chk("pass_ch0", 64'(o0), 64'h01234);
    chk("pass_ch1", 64'(o1), 64'h7FFFF);
    step(1);
    chk("done_pulse", 64'(eqa_Done), 64'd0);
    step(3);
    chk("out_hold", 64'(Eqa_Out), 64'({19'h01234, 19'h7FFFF}));

    // Gain: staging only, then committed 1.5, then 0x20000 which is -2.0 in signed Q2.16.
    wr_coef(0, 18'h00000, 18'h18000);
    run_frame(16'h4000, 16'h0000, o0, o1, lat);
    chk("gain_nocommit", 64'(o0), 64'h04000);
    commit();
    run_frame(16'h4000, 16'h0000, o0, o1, lat);
    chk("gain_1p5", 64'(o0), 64'h06000);
    wr_coef(0, 18'h00000, 18'h20000);
    commit();
    run_frame(16'h4000, 16'h0000, o0, o1, lat);
    chk("gain_m2", 64'(o0), 64'h78000);

    // Saturation across the cascade.
    for (int b = 0; b < NB; b++) wr_coef(b, 18'h00000, 18'h1FFFF);
    commit();
    run_frame(16'h7FFF, 16'h8000, o0, o1, lat);
    chk("sat_pos", 64'(o0), 64'h3FFFF);
    chk("sat_neg", 64'(o1), 64'h40000);

    // Recursion on band 0 with a = 0.5.
    for (int b = 0; b < NB; b++) wr_coef(b, 18'h00000, 18'h10000);
    wr_coef(0, 18'h08000, 18'h10000);
    commit();
    clear_hist();
    run_frame(16'h1000, 16'h0000, o0, o1, lat);
    chk("rec_f1", 64'(o0), 64'h01000);
    run_frame(16'h1000, 16'h0000, o0, o1, lat);
    chk("rec_f2", 64'(o0), 64'h01800);
    run_frame(16'h1000, 16'h0000, o0, o1, lat);
    chk("rec_f3", 64'(o0), 64'h01C00);
    clear_hist();
    run_frame(16'h1000, 16'h0000, o0, o1, lat);
    chk("rec_clr", 64'(o0), 64'h01000);

    // Start and commit during RUN: one Done, old coefficients, new ones next frame.
    wr_coef(0, 18'h00000, 18'h10000);
    commit();
    wr_coef(0, 18'h00000, 18'h18000);
    Eqa_in = {16'h1000, 16'h0000};
    eqa_start = 1'b1; step(1); eqa_start = 1'b0;
    step(4);
    coeff_commit = 1'b1; eqa_start = 1'b1; step(1);
    coeff_commit = 1'b0; eqa_start = 1'b0;
    nd = 0;
    repeat (30) begin
      step(1);
      if (eqa_Done) begin nd++; o0 = Eqa_Out[2*DW-1:DW]; end
    end
    chk("busy_start_dones", 64'(nd), 64'd1);
    chk("busy_commit_old", 64'(o0), 64'h01000);
    run_frame(16'h1000, 16'h0000, o0, o1, lat);
    chk("busy_commit_new", 64'(o0), 64'h01800);

    // Reset in cycle 5 of a frame.
    Eqa_in = {16'h2222, 16'h3333};
    eqa_start = 1'b1; step(1); eqa_start = 1'b0;
    step(4);
    reset_n = 1'b0; step(1); reset_n = 1'b1;
    nd = 0;
    repeat (20) begin step(1); if (eqa_Done) nd++; end
    chk("abort_dones", 64'(nd), 64'd0);
    chk("abort_out", 64'(Eqa_Out), 64'd0);
    chk("abort_busy", 64'(eqa_busy), 64'd0);
    run_frame(16'h0ABC, 16'hF000, o0, o1, lat);
    chk("after_rst_lat", 64'(lat), 64'd12);
    chk("after_rst_ch0", 64'(o0), 64'h00ABC);
    chk("after_rst_ch1", 64'(o1), 64'h7F000);

    // Randomized traffic against the model.
    repeat (3000) begin
      ce           = ($urandom_range(0, 9) != 0);
      eqa_start    = ($urandom_range(0, 3) == 0);
      coeff_wr     = ($urandom_range(0, 3) == 0);
      coeff_band   = 3'($urandom_range(0, 7));
      coeff_a      = 18'($urandom_range(0, 65535)) - 18'h08000;
      coeff_b      = 18'($urandom);
      coeff_commit = ($urandom_range(0, 15) == 0);
      hist_clr     = ($urandom_range(0, 31) == 0);
      band_bypass  = 5'($urandom);
      Eqa_in       = $urandom;
      step(1);
    end
    ce = 1'b1; eqa_start = 1'b0; coeff_wr = 1'b0; coeff_commit = 1'b0; hist_clr = 1'b0;
    step(30);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
